// File: rtl/sat_accum_ctrl_if.sv
// rtl/sat_accum_ctrl_if.sv - sample-in / frame-result-out handshake bundle for sat_accum_ctrl
interface sat_accum_ctrl_if #(
    parameter int N = 16,
    parameter int K = 8
);
    logic                i_valid;
    logic                o_ready;
    logic signed [N-1:0] i_data;
    logic                o_valid;
    logic                i_ready;
    logic signed [K-1:0] o_data;
    logic                o_sat;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/sat_accum_ctrl.sv
// rtl/sat_accum_ctrl.sv - frame accumulator that sums N-bit samples and saturates the sum to K bits
module sat_accum_ctrl #(
    parameter int N     = 16,
    parameter int K     = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [CNT_W-1:0]     i_cfg_len,
    sat_accum_ctrl_if.slave      bus,
    output logic [CNT_W-1:0]     o_sat_cnt
);
    localparam int AW = N + CNT_W;

    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-K+1){1'b0}}, {(K-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-K+1){1'b1}}, {(K-1){1'b0}}};
    localparam logic signed [K-1:0]  OUT_MAX = {1'b0, {(K-1){1'b1}}};
    localparam logic signed [K-1:0]  OUT_MIN = {1'b1, {(K-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

    state_t                 state;
    logic signed [AW-1:0]   acc;
    logic [CNT_W-1:0]       remaining;

    logic                   accept;
    logic signed [AW-1:0]   sample_ext;
    logic [CNT_W-1:0]       len;
    logic                   clip_hi;
    logic                   clip_lo;

    assign bus.o_ready = (state == IDLE) || (state == ACC);
    assign accept      = bus.i_valid && bus.o_ready;
    assign sample_ext  = {{CNT_W{bus.i_data[N-1]}}, bus.i_data};
    // A zero-length frame is treated as a single-sample frame.
    assign len         = (i_cfg_len == '0) ? CNT_ONE : i_cfg_len;
    assign clip_hi     = acc > ACC_MAX;
    assign clip_lo     = acc < ACC_MIN;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            acc         <= '0;
            remaining   <= '0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_sat   <= 1'b0;
            o_sat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc       <= sample_ext;
                        remaining <= len - CNT_ONE;
                        state     <= (len == CNT_ONE) ? SAT : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc       <= acc + sample_ext;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state <= SAT;
                        end
                    end
                end
                SAT: begin
                    if (clip_hi) begin
                        bus.o_data <= OUT_MAX;
                        bus.o_sat  <= 1'b1;
                    end else if (clip_lo) begin
                        bus.o_data <= OUT_MIN;
                        bus.o_sat  <= 1'b1;
                    end else begin
                        bus.o_data <= acc[K-1:0];
                        bus.o_sat  <= 1'b0;
                    end
                    if ((clip_hi || clip_lo) && (o_sat_cnt != '1)) begin
                        o_sat_cnt <= o_sat_cnt + CNT_ONE;
                    end
                    state <= OUT;
                end
                OUT: begin
                    // o_valid rises on the first OUT cycle; the handshake only completes once it is visible.
                    if (!bus.o_valid) begin
                        bus.o_valid <= 1'b1;
                    end else if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
